mm2s_rdata_downsizer: RTL and testbench

Read-data back end of the MM2S path: accepts AXI4 R-channel beats from DDR, buffers them, and splits each MM word into stream-width beats on M_AXIS. Generates TLAST/TSTRB from the programmed byte length, trims padding bytes of the final MM word, and reports RRESP errors. Sits between the MM2S AR/R master logic and the PL peripheral stream port.

---
 rtl/dma_pkg.sv | 24 ++
 rtl/dma_sync_fifo.sv | 55 +++++
 rtl/mm2s_rdata_downsizer.sv | 150 +++++++++++++++
 tb/tb_mm2s_rdata_downsizer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA definitions: AXI response codes, channel state, strobe helper.
package dma_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_e;

  localparam int STRB_MAX = 256;

  // Low nbytes bits set; callers slice to their strobe width.
  function automatic logic [STRB_MAX-1:0] strb_mask(input logic [7:0] nbytes);
    logic [STRB_MAX-1:0] m;
    for (int i = 0; i < STRB_MAX; i++) m[i] = (i < int'(nbytes));
    return m;
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Synchronous FIFO; read data is taken straight from the registered storage at the head.
module dma_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             wr, rd;

  assign full_o    = (cnt == (AW+1)'(DEPTH));
  assign empty_o   = (cnt == '0);
  assign level_o   = cnt;
  assign wr        = wr_en_i && !full_o;
  assign rd        = rd_en_i && !empty_o;
  assign rd_data_o = mem[rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      case ({wr, rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr] <= wr_data_i;
  end

endmodule

// File: rtl/mm2s_rdata_downsizer.sv
// MM2S read-data back end: buffers R beats and splits each MM word into
// stream beats, generating TLAST/TSTRB from the programmed byte length.
module mm2s_rdata_downsizer
  import dma_pkg::*;
#(
  parameter int C_AXI_MM_ID_WIDTH       = 4,
  parameter int C_RID_EXPECTED          = 0,
  parameter int C_AXI_MM_DATA_WIDTH     = 64,
  parameter int C_AXI_STREAM_DATA_WIDTH = 32,
  parameter int C_LENGTH_WIDTH          = 32,
  parameter int C_FIFO_DEPTH            = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 soft_reset_i,
  input  logic                                 xfer_start_i,
  input  logic [C_LENGTH_WIDTH-1:0]            xfer_length_i,
  input  logic [C_AXI_MM_ID_WIDTH-1:0]         m_axi_rid_i,
  input  logic [C_AXI_MM_DATA_WIDTH-1:0]       m_axi_rdata_i,
  input  logic [1:0]                           m_axi_rresp_i,
  input  logic                                 m_axi_rlast_i,
  input  logic                                 m_axi_rvalid_i,
  output logic                                 m_axi_rready_o,
  output logic [C_AXI_STREAM_DATA_WIDTH-1:0]   m_axis_tdata_o,
  output logic [C_AXI_STREAM_DATA_WIDTH/8-1:0] m_axis_tstrb_o,
  output logic                                 m_axis_tlast_o,
  output logic                                 m_axis_tvalid_o,
  input  logic                                 m_axis_tready_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o,
  output logic [$clog2(C_FIFO_DEPTH):0]        fifo_level_o
);
  localparam int MW  = C_AXI_MM_DATA_WIDTH;
  localparam int SW  = C_AXI_STREAM_DATA_WIDTH;
  localparam int SB  = SW / 8;
  localparam int N   = MW / SW;
  localparam int LW  = (N > 1) ? $clog2(N) : 1;
  localparam int LNW = C_LENGTH_WIDTH;

  ch_state_e         state_q, state_d;
  logic [LNW-1:0]    rem_q;
  logic [MW-1:0]     word_q;
  logic              word_vld_q;
  logic [LW-1:0]     lane_q;
  logic              err_q;

  logic [MW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              r_hs, r_err, beat_hs, is_last, lane_end, pop;
  logic [SB-1:0]     strb_tail;
  logic [STRB_MAX-SB-1:0] strb_unused;
  logic              unused_rlast;

  assign unused_rlast = m_axi_rlast_i;

  assign m_axi_rready_o = (state_q == RUN) && !fifo_full;
  assign r_hs  = m_axi_rvalid_i && m_axi_rready_o;
  assign r_err = (m_axi_rresp_i != AXI_RESP_OKAY) ||
                 (m_axi_rid_i != C_AXI_MM_ID_WIDTH'(C_RID_EXPECTED));

  assign beat_hs  = word_vld_q && m_axis_tready_i;
  assign is_last  = word_vld_q && (rem_q <= LNW'(SB));
  assign lane_end = (lane_q == LW'(N-1)) || is_last;
  // Refill when empty, or back-to-back as the last used lane leaves; never past tlast.
  assign pop = (state_q == RUN) && !fifo_empty &&
               (!word_vld_q || (beat_hs && lane_end && !is_last));

  assign {strb_unused, strb_tail} = strb_mask(rem_q[7:0]);

  assign m_axis_tvalid_o = word_vld_q;
  assign m_axis_tdata_o  = word_vld_q ? word_q[int'(lane_q)*SW +: SW] : '0;
  assign m_axis_tstrb_o  = !word_vld_q ? '0 : (is_last ? strb_tail : '1);
  assign m_axis_tlast_o  = is_last;

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign err_o  = err_q;

  dma_sync_fifo #(
    .WIDTH (MW),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (soft_reset_i),
    .wr_en_i   (r_hs),
    .wr_data_i (m_axi_rdata_i),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level_o)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer_start_i) state_d = (xfer_length_i == '0) ? DONE : RUN;
      RUN:     if (beat_hs && is_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (soft_reset_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q      <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      lane_q     <= '0;
      err_q      <= 1'b0;
    end else if (soft_reset_i) begin
      rem_q      <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      lane_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && xfer_start_i) begin
        rem_q <= xfer_length_i;
        err_q <= 1'b0;
      end else if (beat_hs) begin
        rem_q <= (rem_q > LNW'(SB)) ? rem_q - LNW'(SB) : '0;
      end
      if (r_hs && r_err) err_q <= 1'b1;

      if (pop) begin
        word_q     <= fifo_rdata;
        word_vld_q <= 1'b1;
        lane_q     <= '0;
      end else if (beat_hs) begin
        if (lane_end) begin
          word_q     <= '0;
          word_vld_q <= 1'b0;
          lane_q     <= '0;
        end else begin
          lane_q <= lane_q + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mm2s_rdata_downsizer.sv
// Directed bench for the MM2S read-data downsizer (64-bit MM, 32-bit stream).
module tb_mm2s_rdata_downsizer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        soft_reset = 1'b0;
  logic        xfer_start = 1'b0;
  logic [31:0] xfer_length = '0;
  logic [3:0]  rid = '0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast, tvalid;
  logic        tready = 1'b0;
  logic        busy, done, err;
  logic [4:0]  level;

  always #5 clk = ~clk;

  mm2s_rdata_downsizer #(
    .C_AXI_MM_ID_WIDTH       (4),
    .C_RID_EXPECTED          (0),
    .C_AXI_MM_DATA_WIDTH     (64),
    .C_AXI_STREAM_DATA_WIDTH (32),
    .C_LENGTH_WIDTH          (32),
    .C_FIFO_DEPTH            (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .soft_reset_i    (soft_reset),
    .xfer_start_i    (xfer_start),
    .xfer_length_i   (xfer_length),
    .m_axi_rid_i     (rid),
    .m_axi_rdata_i   (rdata),
    .m_axi_rresp_i   (rresp),
    .m_axi_rlast_i   (rlast),
    .m_axi_rvalid_i  (rvalid),
    .m_axi_rready_o  (rready),
    .m_axis_tdata_o  (tdata),
    .m_axis_tstrb_o  (tstrb),
    .m_axis_tlast_o  (tlast),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tready_i (tready),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .fifo_level_o    (level)
  );

  typedef struct {
    int       len;
    int       bad_idx;
    bit       bad_rid;
    int       hold;
    int       exp_beats;
    logic [3:0] last_strb;
    bit       exp_err;
  } vec_t;

  vec_t vecs[9];
  int checks = 0, failures = 0;

  int r_idx, r_n, bad_idx, hold_left, done_cnt, cyc, first_r, first_v, max_level;
  bit bad_rid, prev_stall, err_chk_next;
  logic [63:0] p_bus;
  logic [31:0] bq_data[$];
  logic [3:0]  bq_strb[$];
  logic        bq_last[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_val(input int k);
    logic [31:0] v;
    v = 32'h1111_1111 * 32'(k);
    return v;
  endfunction

  // One clock: drive, observe handshakes that the next edge will take, advance.
  task automatic cycle();
    bit r_hs, s_hs;
    if (r_idx < r_n) begin
      rvalid = 1'b1;
      rdata  = {lane_val(2*r_idx+1), lane_val(2*r_idx)};
      rresp  = (r_idx == bad_idx && !bad_rid) ? 2'b10 : 2'b00;
      rid    = (r_idx == bad_idx && bad_rid) ? 4'd5 : 4'd0;
      rlast  = (r_idx == r_n - 1);
    end else begin
      rvalid = 1'b0; rresp = '0; rid = '0; rlast = 1'b0;
    end
    tready = (hold_left == 0);
    if (err_chk_next) begin
      check("err_set", err, 1);
      err_chk_next = 0;
    end
    if (prev_stall) check("axis_hold", {tvalid, tlast, tstrb, tdata}, p_bus);
    r_hs = rvalid && rready;
    s_hs = tvalid && tready;
    if (r_hs && first_r < 0) first_r = cyc;
    if (tvalid && first_v < 0) first_v = cyc;
    if (s_hs) begin
      bq_data.push_back(tdata);
      bq_strb.push_back(tstrb);
      bq_last.push_back(tlast);
    end
    if (done) done_cnt++;
    if (int'(level) > max_level) max_level = int'(level);
    prev_stall = tvalid && !tready;
    p_bus = {26'd0, tvalid, tlast, tstrb, tdata};
    @(posedge clk); #1;
    if (r_hs && r_idx == bad_idx) err_chk_next = 1;
    if (r_hs) r_idx++;
    if (hold_left > 0) hold_left--;
    cyc++;
  endtask

  task automatic setup(input int len, input int bidx, input bit brid, input int hold);
    r_idx = 0; r_n = (len + 7) / 8; bad_idx = bidx; bad_rid = brid; hold_left = hold;
    done_cnt = 0; cyc = 0; first_r = -1; first_v = -1; max_level = 0;
    prev_stall = 0; err_chk_next = 0;
    bq_data.delete(); bq_strb.delete(); bq_last.delete();
  endtask

  task automatic run_xfer(input vec_t v, input int idx);
    int guard, n;
    setup(v.len, v.bad_idx, v.bad_rid, v.hold);
    xfer_start = 1'b1; xfer_length = v.len;
    cycle();
    xfer_start = 1'b0;
    check("err_clear_on_start", err, 0);
    check("busy_after_start", busy, 1);
    guard = 0;
    while (done_cnt == 0 && guard < 3000) begin
      if (v.hold > 0 && cyc == v.hold) begin
        check("hold_level_full", level, 16);
        check("hold_rready_low", rready, 0);
      end
      cycle();
      guard++;
    end
    if (guard >= 3000) check("done_timeout", 1, 0);
    check("err_final", err, v.exp_err);
    check("busy_idle", busy, 0);
    n = bq_data.size();
    check("beat_count", n, v.exp_beats);
    for (int i = 0; i < n; i++) begin
      check("tdata", bq_data[i], lane_val(i));
      check("tstrb", bq_strb[i], (i == n-1) ? v.last_strb : 4'hF);
      check("tlast", bq_last[i], (i == n-1));
    end
    check("r_beats_taken", r_idx, r_n);
    cycle(); cycle();
    check("done_single", done_cnt, 1);
    if (idx == 0) check("latency_r_to_tvalid", first_v - first_r, 2);
    if (v.hold > 0) check("max_level", max_level, 16);
  endtask

  initial begin
    vecs[0] = '{16,  -1, 0, 0,  4,  4'hF, 0};
    vecs[1] = '{13,  -1, 0, 0,  4,  4'h1, 0};
    vecs[2] = '{12,  -1, 0, 0,  3,  4'hF, 0};
    vecs[3] = '{256, -1, 0, 40, 64, 4'hF, 0};
    vecs[4] = '{32,   2, 0, 0,  8,  4'hF, 1};
    vecs[5] = '{8,   -1, 0, 0,  2,  4'hF, 0};
    vecs[6] = '{0,   -1, 0, 0,  0,  4'hF, 0};
    vecs[7] = '{5,    0, 1, 0,  2,  4'h1, 1};
    vecs[8] = '{7,   -1, 0, 0,  2,  4'h7, 0};

    setup(0, -1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rready", rready, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_level", level, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tstrb", tstrb, 0);

    for (int k = 0; k < 9; k++) run_xfer(vecs[k], k);

    // Abort after three stream beats; nothing of it may survive.
    begin
      int guard;
      setup(32, -1, 0, 0);
      xfer_start = 1'b1; xfer_length = 32;
      cycle();
      xfer_start = 1'b0;
      guard = 0;
      while (bq_data.size() < 3 && guard < 200) begin cycle(); guard++; end
      check("sr_three_beats", bq_data.size(), 3);
      r_n = 0;
      soft_reset = 1'b1;
      cycle();
      soft_reset = 1'b0;
      check("sr_tvalid", tvalid, 0);
      check("sr_busy", busy, 0);
      check("sr_level", level, 0);
      check("sr_done", done, 0);
      cycle(); cycle(); cycle();
      check("sr_no_done", done_cnt, 0);
      run_xfer(vecs[5], 99);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
